// File: rtl/jk_seq_arbiter.sv
// Two-way round-robin sequencer for the shared JK machine: clears it, shifts a
// latched pattern into x LSB first, counts F hits. Optional macro: JK_SEQ_FIRSTHIT_EN.
module jk_seq_arbiter #(
  parameter int W  = 16,
  parameter int LW = 5,
  parameter int CW = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          req1,
  input  logic [W-1:0]  pat0,
  input  logic [W-1:0]  pat1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] hits,
  output logic [LW-1:0] first_hit,
  output logic [2:0]    final_s,
  output logic          dut_x,
  output logic          dut_reset,
  input  logic          dut_f,
  input  logic [2:0]    dut_s
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, TAIL, DONE} state_t;

  state_t        state, state_n;
  logic          ptr;
  logic          win, win_n;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q, idx;
  logic [LW-1:0] len_sel, len_clamp;
  logic          samp;
  logic [1:0]    gnt_n;
  logic          busy_n, done_n, dut_reset_n, dut_x_n;

  assign len_sel   = win_n ? len1 : len0;
  assign len_clamp = (len_sel > LW'(W)) ? LW'(W) : len_sel;

  // RUN cycle 0 has no prior bit to score; TAIL scores the last bit
  assign samp = ((state == RUN) && (idx != '0)) || ((state == TAIL) && (len_q != '0));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    win_n   = win;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_n = CLEAR;
          if (req0 && req1) win_n = ~ptr;
          else              win_n = req1;
        end
      end
      CLEAR:   state_n = (len_q == '0) ? TAIL : RUN;
      RUN:     if (idx == len_q - LW'(1)) state_n = TAIL;
      TAIL:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state
  always_comb begin
    gnt_n       = '0;
    if (state_n != IDLE) gnt_n = win_n ? 2'b10 : 2'b01;
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
    dut_reset_n = (state_n == CLEAR);
    dut_x_n     = (state_n == RUN) && pat_q[0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_x     <= 1'b0;
      dut_reset <= 1'b1;
    end else begin
      gnt       <= gnt_n;
      busy      <= busy_n;
      done      <= done_n;
      dut_x     <= dut_x_n;
      dut_reset <= dut_reset_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr     <= 1'b1;
      win     <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      hits    <= '0;
      final_s <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_n == CLEAR) begin
            win     <= win_n;
            pat_q   <= win_n ? pat1 : pat0;
            len_q   <= len_clamp;
            hits    <= '0;
            final_s <= '0;
          end
        end
        CLEAR: begin
          idx   <= '0;
          pat_q <= pat_q >> 1;
        end
        RUN: begin
          idx   <= idx + LW'(1);
          pat_q <= pat_q >> 1;
        end
        TAIL:    final_s <= dut_s;
        DONE:    ptr <= win;
        default: ;
      endcase
      if (samp && dut_f && (hits != '1)) hits <= hits + CW'(1);
    end
  end

`ifdef JK_SEQ_FIRSTHIT_EN
  logic [LW-1:0] samp_idx;
  assign samp_idx = (state == RUN) ? (idx - LW'(1)) : (len_q - LW'(1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      first_hit <= '1;
    end else if ((state == IDLE) && (state_n == CLEAR)) begin
      first_hit <= '1;
    end else if (samp && dut_f && (first_hit == '1)) begin
      first_hit <= samp_idx;
    end
  end
`else
  assign first_hit = '1;
`endif

endmodule

// File: tb/tb_jk_seq_arbiter.sv
// Directed bench for jk_seq_arbiter with a reduced JK machine model per instance;
// a second instance with CW=2 covers hit-counter saturation.
module tb_jk_seq_arbiter;

  logic        CLK;
  logic        RESET;
  logic        req0, req1;
  logic [15:0] pat0, pat1;
  logic [4:0]  len0, len1;

  logic [1:0]  gnt, gnt2;
  logic        busy, busy2, done, done2;
  logic [4:0]  hits;
  logic [1:0]  hits2;
  logic [4:0]  first_hit, first_hit2;
  logic [2:0]  final_s, final_s2;
  logic        dut_x, dut_x2, dut_reset, dut_reset2;
  logic [2:0]  ms, ms2;
  logic        mf, mf2;

  int n_chk = 0;
  int n_err = 0;

  jk_seq_arbiter #(.W(16), .LW(5), .CW(5)) u_dut (
    .CLK(CLK), .RESET(RESET), .req0(req0), .req1(req1),
    .pat0(pat0), .pat1(pat1), .len0(len0), .len1(len1),
    .gnt(gnt), .busy(busy), .done(done), .hits(hits),
    .first_hit(first_hit), .final_s(final_s),
    .dut_x(dut_x), .dut_reset(dut_reset), .dut_f(mf), .dut_s(ms)
  );

  jk_seq_arbiter #(.W(16), .LW(5), .CW(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .req0(req0), .req1(req1),
    .pat0(pat0), .pat1(pat1), .len0(len0), .len1(len1),
    .gnt(gnt2), .busy(busy2), .done(done2), .hits(hits2),
    .first_hit(first_hit2), .final_s(final_s2),
    .dut_x(dut_x2), .dut_reset(dut_reset2), .dut_f(mf2), .dut_s(ms2)
  );

  // Transitions the machine is documented to take; F is high in state 111
  function automatic logic [2:0] jk_next(input logic [2:0] s, input logic x);
    case ({s, x})
      4'b000_1: return 3'b101;
      4'b101_1: return 3'b110;
      4'b110_1: return 3'b010;
      4'b010_0: return 3'b111;
      4'b111_0: return 3'b000;
      4'b111_1: return 3'b101;
      default:  return 3'b000;
    endcase
  endfunction

  always @(posedge CLK) begin
    ms  <= dut_reset  ? 3'b000 : jk_next(ms, dut_x);
    ms2 <= dut_reset2 ? 3'b000 : jk_next(ms2, dut_x2);
  end
  assign mf  = (ms == 3'b111);
  assign mf2 = (ms2 == 3'b111);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [4:0] fh(input logic [4:0] v);
`ifdef JK_SEQ_FIRSTHIT_EN
    return v;
`else
    return 5'h1F;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic r0, input logic r1, input logic hold);
    @(negedge CLK);
    req0 = r0;
    req1 = r1;
    @(posedge CLK);
    #1;
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  // Starts in the CLEAR cycle; k counts cycles after the request edge
  task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_x,
                           input logic [1:0] exp_gnt);
    int k;
    int nrst;
    logic [31:0] xs;
    logic got_done;
    xs = '0;
    nrst = 0;
    got_done = 1'b0;
    for (k = 1; k <= 30; k++) begin
      @(negedge CLK);
      xs[k] = dut_x;
      if (dut_reset) nrst++;
      if (k == 1) check({tag, " clear gnt"}, 32'(gnt), 32'(exp_gnt));
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check({tag, " done seen"}, 32'(got_done), 32'd1);
    check({tag, " done cycle"}, k, exp_cyc);
    check({tag, " x stream"}, xs, exp_x);
    check({tag, " clear pulses"}, nrst, 32'd1);
    check({tag, " done gnt"}, 32'(gnt), 32'(exp_gnt));
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle gnt"}, 32'(gnt), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [4:0] h, input logic [4:0] f,
                           input logic [2:0] s);
    check({tag, " hits"}, 32'(hits), 32'(h));
    check({tag, " first_hit"}, 32'(first_hit), 32'(f));
    check({tag, " final_s"}, 32'(final_s), 32'(s));
  endtask

  initial begin
    int seen_done;
    req0 = 1'b0; req1 = 1'b0;
    pat0 = '0; pat1 = '0; len0 = '0; len1 = '0;
    RESET = 1'b1;
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst dut_x", 32'(dut_x), 32'd0);
    check("rst dut_reset", 32'(dut_reset), 32'd1);
    check_res("rst", 5'd0, 5'h1F, 3'b000);
    RESET = 1'b1;
    @(negedge CLK);
    check("post-rst dut_reset", 32'(dut_reset), 32'd0);

    // Tie from reset, both held: 01, 10, 01 with an IDLE cycle between
    pat0 = 16'h0007; len0 = 5'd4;
    pat1 = 16'h0001; len1 = 5'd1;
    issue(1'b1, 1'b1, 1'b1);
    wait_done("tie1", 7, 32'h1C, 2'b01);
    check_res("tie1", 5'd1, fh(5'd3), 3'b111);
    check_idle("tie1");
    wait_done("tie2", 4, 32'h4, 2'b10);
    check_res("tie2", 5'd0, 5'h1F, 3'b101);
    check_idle("tie2");
    wait_done("tie3", 7, 32'h1C, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    check_res("tie3", 5'd1, fh(5'd3), 3'b111);
    check_idle("tie3");
    check("tie3 held hits", 32'(hits), 32'd1);

    // Single requester, len 4 and len 5
    issue(1'b1, 1'b0, 1'b0);
    wait_done("len4", 7, 32'h1C, 2'b01);
    check_res("len4", 5'd1, fh(5'd3), 3'b111);
    check("len4 cw2 hits", 32'(hits2), 32'd1);
    len0 = 5'd5;
    issue(1'b1, 1'b0, 1'b0);
    wait_done("len5", 8, 32'h1C, 2'b01);
    check_res("len5", 5'd1, fh(5'd3), 3'b000);

    // Zero length
    pat1 = 16'hFFFF; len1 = 5'd0;
    issue(1'b0, 1'b1, 1'b0);
    wait_done("len0", 3, 32'h0, 2'b10);
    check_res("len0", 5'd0, 5'h1F, 3'b000);

    // Repeating 0111 over 16 bits: 4 hits, CW=2 saturates at 3
    pat0 = 16'h7777; len0 = 5'd16;
    issue(1'b1, 1'b0, 1'b0);
    wait_done("rep", 19, 32'h1DDDC, 2'b01);
    check_res("rep", 5'd4, fh(5'd3), 3'b111);
    check("rep cw2 hits", 32'(hits2), 32'd3);

    // Length above W is clamped to W
    len0 = 5'd31;
    issue(1'b1, 1'b0, 1'b0);
    wait_done("clamp", 19, 32'h1DDDC, 2'b01);
    check_res("clamp", 5'd4, fh(5'd3), 3'b111);

    // Reset in RUN bit 2 discards the transaction
    pat0 = 16'h0007; len0 = 5'd4;
    issue(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("midrst gnt", 32'(gnt), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst dut_reset", 32'(dut_reset), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    check_res("midrst", 5'd0, 5'h1F, 3'b000);
    seen_done = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done) seen_done++;
    end
    RESET = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (done) seen_done++;
    end
    check("midrst no done", seen_done, 32'd0);
    issue(1'b1, 1'b0, 1'b0);
    wait_done("after", 7, 32'h1C, 2'b01);
    check_res("after", 5'd1, fh(5'd3), 3'b111);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
